// File: rtl/csr_mngr_file_if.sv
// Core/manager-facing signal bundle of csr_mngr_file.
// The core and manager drive through master; the CSR file uses slave.
interface csr_mngr_file_if #(
   parameter int unsigned CNT_WIDTH = 64
) ();
   logic                 CSR_Read;
   logic                 CSR_Write;
   logic [11:0]          CSR_Address;
   logic [31:0]          CSR_Wr_Data;
   logic                 Completed_Instruction;
   logic                 Stall;
   logic [31:0]          CSR_Rd_Data;
   logic                 CSR_Rd_Valid;
   logic                 Illegal_CSR;
   logic [31:0]          Mngr2Proc_Data;
   logic                 Mngr2Proc_Valid;
   logic                 Mngr2Proc_Ready;
   logic [31:0]          Proc2Mngr_Data;
   logic                 Proc2Mngr_Valid;
   logic                 Proc2Mngr_Ready;
   logic [CNT_WIDTH-1:0] Clock_Cycles;
   logic [CNT_WIDTH-1:0] Completed_Instructions;

   modport master (
      output CSR_Read, CSR_Write, CSR_Address, CSR_Wr_Data, Completed_Instruction,
      output Mngr2Proc_Data, Mngr2Proc_Valid, Proc2Mngr_Ready,
      input  Stall, CSR_Rd_Data, CSR_Rd_Valid, Illegal_CSR,
      input  Mngr2Proc_Ready, Proc2Mngr_Data, Proc2Mngr_Valid,
      input  Clock_Cycles, Completed_Instructions
   );

   modport slave (
      input  CSR_Read, CSR_Write, CSR_Address, CSR_Wr_Data, Completed_Instruction,
      input  Mngr2Proc_Data, Mngr2Proc_Valid, Proc2Mngr_Ready,
      output Stall, CSR_Rd_Data, CSR_Rd_Valid, Illegal_CSR,
      output Mngr2Proc_Ready, Proc2Mngr_Data, Proc2Mngr_Valid,
      output Clock_Cycles, Completed_Instructions
   );
endinterface

// File: rtl/csr_mngr_file.sv
// CSR file for the RV32IM core: manager message FIFOs, cycle/instret counters,
// identity/status CSRs and illegal-access detection. Stall holds a blocked FIFO access.
module csr_mngr_file #(
   parameter int unsigned CORE_ID    = 0,
   parameter int unsigned NUM_CORES  = 1,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_WIDTH  = 64
) (
   input logic            Clk,
   input logic            Rst_n,
   csr_mngr_file_if.slave bus
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [11:0] ADDR_CORE_ID   = 12'hF14;
   localparam logic [11:0] ADDR_NUM_CORES = 12'hFC1;
   localparam logic [11:0] ADDR_STATS_EN  = 12'h7C1;
   localparam logic [11:0] ADDR_MNGR2PROC = 12'hFC0;
   localparam logic [11:0] ADDR_PROC2MNGR = 12'h7C0;
   localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
   localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
   localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
   localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
   localparam logic [11:0] ADDR_STATUS    = 12'h7C2;

   logic [31:0]          rx_mem_q [FIFO_DEPTH];
   logic [31:0]          tx_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
   logic [PTR_W-1:0]     tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
   logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
   logic                 stats_en_q, stats_en_d;
   logic [CNT_WIDTH-1:0] cyc_q, cyc_d, ins_q, ins_d;
   logic [31:0]          rd_data_q, rd_data_d;
   logic                 rd_valid_q, rd_valid_d;
   logic                 illegal_q, illegal_d;

   logic        stall_c, accept, rd_acc, wr_acc;
   logic        rd_legal, wr_legal;
   logic        rx_ready, rx_push, rx_pop, tx_push, tx_pop, en_wr;
   logic [31:0] rd_mux;
   logic [63:0] cyc64, ins64;

   // Address decode, read mux and access acceptance
   always_comb begin
      rd_mux   = '0;
      rd_legal = 1'b1;
      cyc64    = 64'(cyc_q);
      ins64    = 64'(ins_q);
      case (bus.CSR_Address)
         ADDR_CORE_ID:   rd_mux = 32'(CORE_ID);
         ADDR_NUM_CORES: rd_mux = 32'(NUM_CORES);
         ADDR_STATS_EN:  rd_mux = {31'b0, stats_en_q};
         ADDR_MNGR2PROC: rd_mux = rx_mem_q[rx_rptr_q];
         ADDR_PROC2MNGR: rd_mux = '0;
         ADDR_CYCLE:     rd_mux = cyc64[31:0];
         ADDR_CYCLEH:    rd_mux = cyc64[63:32];
         ADDR_INSTRET:   rd_mux = ins64[31:0];
         ADDR_INSTRETH:  rd_mux = ins64[63:32];
         ADDR_STATUS:    rd_mux = {16'b0, 8'(rx_cnt_q), 8'(tx_cnt_q)};
         default:        rd_legal = 1'b0;
      endcase
      wr_legal = (bus.CSR_Address == ADDR_STATS_EN) || (bus.CSR_Address == ADDR_PROC2MNGR);

      stall_c = (bus.CSR_Read  && (bus.CSR_Address == ADDR_MNGR2PROC) && (rx_cnt_q == '0)) ||
                (bus.CSR_Write && (bus.CSR_Address == ADDR_PROC2MNGR) &&
                 (tx_cnt_q == CNT_W'(FIFO_DEPTH)));
      accept  = (bus.CSR_Read || bus.CSR_Write) && !stall_c;
      rd_acc  = accept && bus.CSR_Read;
      wr_acc  = accept && bus.CSR_Write;

      rx_ready = Rst_n && (rx_cnt_q < CNT_W'(FIFO_DEPTH));
      rx_push  = bus.Mngr2Proc_Valid && rx_ready;
      rx_pop   = rd_acc && (bus.CSR_Address == ADDR_MNGR2PROC);
      tx_pop   = (tx_cnt_q != '0) && bus.Proc2Mngr_Ready;
      tx_push  = wr_acc && (bus.CSR_Address == ADDR_PROC2MNGR);
      en_wr    = wr_acc && (bus.CSR_Address == ADDR_STATS_EN);
   end

   // Next-state for FIFOs, counters and read response
   always_comb begin
      rx_wptr_d  = rx_wptr_q + PTR_W'(rx_push);
      rx_rptr_d  = rx_rptr_q + PTR_W'(rx_pop);
      rx_cnt_d   = rx_cnt_q + CNT_W'(rx_push) - CNT_W'(rx_pop);
      tx_wptr_d  = tx_wptr_q + PTR_W'(tx_push);
      tx_rptr_d  = tx_rptr_q + PTR_W'(tx_pop);
      tx_cnt_d   = tx_cnt_q + CNT_W'(tx_push) - CNT_W'(tx_pop);

      stats_en_d = en_wr ? bus.CSR_Wr_Data[0] : stats_en_q;
      cyc_d      = cyc_q;
      ins_d      = ins_q;
      // 0->1 clears; counting only on edges where enable stays high across the edge
      if (stats_en_d && !stats_en_q) begin
         cyc_d = '0;
         ins_d = '0;
      end else if (stats_en_d && stats_en_q) begin
         cyc_d = cyc_q + CNT_WIDTH'(1);
         ins_d = ins_q + CNT_WIDTH'(bus.Completed_Instruction);
      end

      rd_valid_d = rd_acc;
      rd_data_d  = rd_data_q;
      if (rd_acc) rd_data_d = rd_legal ? rd_mux : 32'h0;
      illegal_d  = (rd_acc && !rd_legal) || (wr_acc && !wr_legal);
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         rx_wptr_q  <= '0;
         rx_rptr_q  <= '0;
         rx_cnt_q   <= '0;
         tx_wptr_q  <= '0;
         tx_rptr_q  <= '0;
         tx_cnt_q   <= '0;
         stats_en_q <= 1'b0;
         cyc_q      <= '0;
         ins_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         rx_wptr_q  <= rx_wptr_d;
         rx_rptr_q  <= rx_rptr_d;
         rx_cnt_q   <= rx_cnt_d;
         tx_wptr_q  <= tx_wptr_d;
         tx_rptr_q  <= tx_rptr_d;
         tx_cnt_q   <= tx_cnt_d;
         stats_en_q <= stats_en_d;
         cyc_q      <= cyc_d;
         ins_q      <= ins_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         illegal_q  <= illegal_d;
      end
   end

   // Storage needs no reset: empty pointers mask stale entries
   always_ff @(posedge Clk) begin
      if (rx_push) rx_mem_q[rx_wptr_q] <= bus.Mngr2Proc_Data;
      if (tx_push) tx_mem_q[tx_wptr_q] <= bus.CSR_Wr_Data;
   end

   assign bus.Stall                  = stall_c;
   assign bus.CSR_Rd_Data            = rd_data_q;
   assign bus.CSR_Rd_Valid           = rd_valid_q;
   assign bus.Illegal_CSR            = illegal_q;
   assign bus.Mngr2Proc_Ready        = rx_ready;
   assign bus.Proc2Mngr_Data         = tx_mem_q[tx_rptr_q];
   assign bus.Proc2Mngr_Valid        = tx_cnt_q != '0;
   assign bus.Clock_Cycles           = cyc_q;
   assign bus.Completed_Instructions = ins_q;

endmodule

// File: tb/tb_csr_mngr_file.sv
// Bench for csr_mngr_file: vector table, directed FIFO/counter/reset sequences
// and random traffic, all checked against a queue-based reference model.
module tb_csr_mngr_file;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = 64;

   logic Clk = 1'b0;
   logic Rst_n;
   csr_mngr_file_if #(.CNT_WIDTH(CW)) bus ();

   csr_mngr_file #(
      .CORE_ID(2), .NUM_CORES(4), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)
   ) dut (
      .Clk(Clk), .Rst_n(Rst_n), .bus(bus)
   );

   always #5 Clk = ~Clk;

   int total = 0;
   int bad   = 0;
   logic last_stall;

   // Reference model state
   logic [31:0] rxq[$];
   logic [31:0] txq[$];
   logic [31:0] seen[$];
   bit          m_en;
   logic [63:0] m_cyc, m_ins;
   logic [31:0] m_rd_data;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_clear();
      rxq.delete();
      txq.delete();
      m_en      = 1'b0;
      m_cyc     = '0;
      m_ins     = '0;
      m_rd_data = '0;
   endfunction

   function automatic void model_read(input logic [11:0] a, output logic [31:0] v, output bit legal);
      legal = 1'b1;
      v     = '0;
      case (a)
         12'hF14: v = 32'd2;
         12'hFC1: v = 32'd4;
         12'h7C1: v = {31'b0, m_en};
         12'hFC0: if (rxq.size() > 0) v = rxq[0];
         12'h7C0: v = '0;
         12'hC00: v = m_cyc[31:0];
         12'hC80: v = m_cyc[63:32];
         12'hC02: v = m_ins[31:0];
         12'hC82: v = m_ins[63:32];
         12'h7C2: v = 32'((rxq.size() * 256) + txq.size());
         default: legal = 1'b0;
      endcase
   endfunction

   task automatic set_acc(input logic rd, input logic wr, input logic [11:0] a, input logic [31:0] wd);
      bus.CSR_Read    = rd;
      bus.CSR_Write   = wr;
      bus.CSR_Address = a;
      bus.CSR_Wr_Data = wd;
   endtask

   // One clock: check combinational outputs mid-cycle, advance model, check registered outputs
   task automatic step();
      logic        rd, wr, ci, mv, pr, st, acc, e_valid, e_ill, en_new;
      logic [11:0] a;
      logic [31:0] wd, md, rv;
      bit          rl, rx_pop, rx_push, tx_push, tx_pop;
      @(negedge Clk);
      rd = bus.CSR_Read; wr = bus.CSR_Write; a = bus.CSR_Address; wd = bus.CSR_Wr_Data;
      ci = bus.Completed_Instruction; mv = bus.Mngr2Proc_Valid; md = bus.Mngr2Proc_Data;
      pr = bus.Proc2Mngr_Ready;
      st = (rd && a == 12'hFC0 && rxq.size() == 0) || (wr && a == 12'h7C0 && txq.size() == DEPTH);
      chk("stall", bus.Stall, st);
      last_stall = bus.Stall;
      if (bus.Proc2Mngr_Valid && bus.Proc2Mngr_Ready) seen.push_back(bus.Proc2Mngr_Data);
      acc = (rd || wr) && !st;
      model_read(a, rv, rl);
      e_valid = acc && rd;
      e_ill   = acc && ((rd && !rl) || (wr && !(a == 12'h7C1 || a == 12'h7C0)));
      if (e_valid) m_rd_data = rl ? rv : 32'h0;
      rx_pop  = acc && rd && a == 12'hFC0;
      tx_push = acc && wr && a == 12'h7C0;
      rx_push = mv && rxq.size() < DEPTH;
      tx_pop  = pr && txq.size() > 0;
      en_new  = (acc && wr && a == 12'h7C1) ? wd[0] : m_en;
      @(posedge Clk);
      if (rx_pop)  void'(rxq.pop_front());
      if (rx_push) rxq.push_back(md);
      if (tx_pop)  void'(txq.pop_front());
      if (tx_push) txq.push_back(wd);
      if (en_new && !m_en) begin
         m_cyc = '0;
         m_ins = '0;
      end else if (en_new && m_en) begin
         m_cyc = m_cyc + 64'd1;
         m_ins = m_ins + 64'(ci);
      end
      m_en = en_new;
      #1;
      chk("rd_valid", bus.CSR_Rd_Valid, e_valid);
      if (e_valid) chk("rd_data", bus.CSR_Rd_Data, m_rd_data);
      chk("illegal", bus.Illegal_CSR, e_ill);
      chk("cycles", bus.Clock_Cycles, m_cyc);
      chk("instret", bus.Completed_Instructions, m_ins);
      chk("m2p_ready", bus.Mngr2Proc_Ready, rxq.size() < DEPTH);
      chk("p2m_valid", bus.Proc2Mngr_Valid, txq.size() > 0);
      if (txq.size() > 0) chk("p2m_data", bus.Proc2Mngr_Data, txq[0]);
   endtask

   // Asynchronous reset asserted between edges while inputs stay active
   task automatic mid_reset();
      #2;
      Rst_n = 1'b0;
      model_clear();
      #1;
      chk("rst_stall", bus.Stall, 1'b0);
      chk("rst_m2p_ready", bus.Mngr2Proc_Ready, 1'b0);
      chk("rst_p2m_valid", bus.Proc2Mngr_Valid, 1'b0);
      set_acc(1'b0, 1'b0, 12'h0, 32'h0);
      bus.Mngr2Proc_Valid = 1'b0;
      @(posedge Clk);
      #1;
      Rst_n = 1'b1;
   endtask

   typedef struct {
      logic        rd;
      logic        wr;
      logic [11:0] addr;
      logic [31:0] wd;
      logic        e_valid;
      logic [31:0] e_data;
      logic        e_ill;
   } vec_t;

   vec_t        vecs[9];
   logic [11:0] addrs[12];

   initial begin
      vecs[0] = '{1'b1, 1'b0, 12'hF14, 32'h0,   1'b1, 32'd2, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 12'hFC1, 32'h0,   1'b1, 32'd4, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 12'h7C1, 32'h0,   1'b1, 32'd0, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 12'h123, 32'h0,   1'b1, 32'd0, 1'b1};
      vecs[4] = '{1'b0, 1'b1, 12'hF14, 32'hFF,  1'b0, 32'd0, 1'b1};
      vecs[5] = '{1'b1, 1'b1, 12'hF14, 32'hFF,  1'b1, 32'd2, 1'b1};
      vecs[6] = '{1'b1, 1'b0, 12'h7C2, 32'h0,   1'b1, 32'd0, 1'b0};
      vecs[7] = '{1'b0, 1'b1, 12'h7C1, 32'h0,   1'b0, 32'd0, 1'b0};
      vecs[8] = '{1'b1, 1'b0, 12'hC80, 32'h0,   1'b1, 32'd0, 1'b0};
      addrs = '{12'hF14, 12'hFC1, 12'h7C1, 12'hFC0, 12'h7C0, 12'hC00,
                12'hC80, 12'hC02, 12'hC82, 12'h7C2, 12'h123, 12'hF15};

      // Reset with the manager already offering data
      Rst_n = 1'b0;
      set_acc(1'b0, 1'b0, 12'h0, 32'h0);
      bus.Completed_Instruction = 1'b0;
      bus.Mngr2Proc_Data  = 32'h0;
      bus.Mngr2Proc_Valid = 1'b1;
      bus.Proc2Mngr_Ready = 1'b0;
      model_clear();
      #12;
      chk("reset_m2p_ready", bus.Mngr2Proc_Ready, 1'b0);
      chk("reset_p2m_valid", bus.Proc2Mngr_Valid, 1'b0);
      chk("reset_rd_valid", bus.CSR_Rd_Valid, 1'b0);
      chk("reset_rd_data", bus.CSR_Rd_Data, 32'h0);
      chk("reset_illegal", bus.Illegal_CSR, 1'b0);
      chk("reset_cycles", bus.Clock_Cycles, 64'h0);
      chk("reset_instret", bus.Completed_Instructions, 64'h0);
      bus.Mngr2Proc_Valid = 1'b0;
      @(posedge Clk);
      #1;
      Rst_n = 1'b1;

      // Register/illegal-access vector table
      foreach (vecs[i]) begin
         set_acc(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd);
         step();
         chk($sformatf("vec%0d_valid", i), bus.CSR_Rd_Valid, vecs[i].e_valid);
         if (vecs[i].e_valid) chk($sformatf("vec%0d_data", i), bus.CSR_Rd_Data, vecs[i].e_data);
         chk($sformatf("vec%0d_ill", i), bus.Illegal_CSR, vecs[i].e_ill);
      end
      set_acc(1'b0, 1'b0, 12'h0, 32'h0);
      step();

      // rx FIFO: fill, drain, stall on empty, no same-cycle bypass
      for (int i = 0; i < 4; i++) begin
         bus.Mngr2Proc_Valid = 1'b1;
         bus.Mngr2Proc_Data  = 32'hA + 32'(i);
         step();
      end
      bus.Mngr2Proc_Valid = 1'b0;
      chk("rx_full_ready", bus.Mngr2Proc_Ready, 1'b0);
      for (int i = 0; i < 4; i++) begin
         set_acc(1'b1, 1'b0, 12'hFC0, 32'h0);
         step();
         chk("rx_pop_data", bus.CSR_Rd_Data, 32'hA + 32'(i));
      end
      step();
      chk("rx_empty_stall", last_stall, 1'b1);
      bus.Mngr2Proc_Valid = 1'b1;
      bus.Mngr2Proc_Data  = 32'hE;
      step();
      chk("rx_no_bypass", last_stall, 1'b1);
      bus.Mngr2Proc_Valid = 1'b0;
      step();
      chk("rx_unstall", last_stall, 1'b0);
      chk("rx_late_data", bus.CSR_Rd_Data, 32'hE);
      chk("rx_late_valid", bus.CSR_Rd_Valid, 1'b1);
      set_acc(1'b0, 1'b0, 12'h0, 32'h0);
      step();

      // tx FIFO: fill, stall when full, manager drains in order
      seen.delete();
      for (int i = 1; i <= 5; i++) begin
         set_acc(1'b0, 1'b1, 12'h7C0, 32'(i));
         step();
      end
      chk("tx_full_stall", last_stall, 1'b1);
      set_acc(1'b1, 1'b0, 12'h7C2, 32'h0);
      step();
      chk("tx_status", bus.CSR_Rd_Data, 32'h0004);
      set_acc(1'b0, 1'b1, 12'h7C0, 32'd5);
      bus.Proc2Mngr_Ready = 1'b1;
      step();
      chk("tx_pop_same_cycle_stall", last_stall, 1'b1);
      step();
      chk("tx_unstall", last_stall, 1'b0);
      set_acc(1'b0, 1'b0, 12'h0, 32'h0);
      repeat (6) step();
      chk("tx_seen_count", 64'(seen.size()), 64'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < seen.size()) chk("tx_seen_order", seen[i], 32'(i + 1));
      end

      // Statistics counters: enable, count 10, freeze, re-enable clears
      set_acc(1'b0, 1'b1, 12'h7C1, 32'h1);
      step();
      set_acc(1'b0, 1'b0, 12'h0, 32'h0);
      bus.Completed_Instruction = 1'b1;
      repeat (10) step();
      bus.Completed_Instruction = 1'b0;
      set_acc(1'b0, 1'b1, 12'h7C1, 32'h0);
      step();
      set_acc(1'b1, 1'b0, 12'hC00, 32'h0);
      step();
      chk("cnt_cycle", bus.CSR_Rd_Data, 32'd10);
      set_acc(1'b1, 1'b0, 12'hC02, 32'h0);
      step();
      chk("cnt_instret", bus.CSR_Rd_Data, 32'd10);
      set_acc(1'b1, 1'b0, 12'hC80, 32'h0);
      step();
      chk("cnt_cycle_hi", bus.CSR_Rd_Data, 32'd0);
      set_acc(1'b0, 1'b1, 12'h7C1, 32'h1);
      step();
      set_acc(1'b1, 1'b0, 12'hC00, 32'h0);
      step();
      chk("cnt_clear_cycle", bus.CSR_Rd_Data, 32'd0);
      set_acc(1'b0, 1'b1, 12'h7C1, 32'h1);
      step();
      set_acc(1'b1, 1'b0, 12'hC00, 32'h0);
      step();
      chk("cnt_no_reclear", bus.CSR_Rd_Data, 32'd2);
      set_acc(1'b0, 1'b1, 12'h7C1, 32'h0);
      step();

      // Reset while stalled on a full tx FIFO with rx holding data
      bus.Proc2Mngr_Ready = 1'b0;
      bus.Mngr2Proc_Valid = 1'b1;
      bus.Mngr2Proc_Data  = 32'h55;
      for (int i = 0; i < 5; i++) begin
         set_acc(1'b0, 1'b1, 12'h7C0, 32'h100 + 32'(i));
         step();
      end
      chk("mid_pre_stall", last_stall, 1'b1);
      mid_reset();
      set_acc(1'b1, 1'b0, 12'h7C2, 32'h0);
      step();
      chk("mid_status", bus.CSR_Rd_Data, 32'h0);
      set_acc(1'b1, 1'b0, 12'hFC0, 32'h0);
      step();
      chk("mid_rx_stall", last_stall, 1'b1);
      set_acc(1'b0, 1'b0, 12'h0, 32'h0);
      step();

      // Random traffic: first biased toward full FIFOs, then toward empty
      for (int n = 0; n < 3000; n++) begin
         int r;
         r = int'($urandom_range(0, 9));
         set_acc(r < 4, (r >= 3) && (r < 6), addrs[$urandom_range(0, 11)], $urandom);
         bus.Completed_Instruction = 1'($urandom_range(0, 1));
         bus.Mngr2Proc_Data  = $urandom;
         if (n < 1500) begin
            bus.Mngr2Proc_Valid = $urandom_range(0, 3) != 0;
            bus.Proc2Mngr_Ready = $urandom_range(0, 3) == 0;
         end else begin
            bus.Mngr2Proc_Valid = $urandom_range(0, 3) == 0;
            bus.Proc2Mngr_Ready = $urandom_range(0, 3) != 0;
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/csr_mngr_file.md
Name: csr_mngr_file

Overview:
Parametrised CSR file for the RV32IM core, next generation of the core's CSR block. It provides separate depth-configurable manager-to-proc and proc-to-manager FIFOs with valid/ready manager-side handshakes. It also provides width-configurable cycle and instret statistics counters readable as CSRs, and flags illegal CSR accesses. It sits beside the execute stage and stalls the pipeline while a FIFO CSR access cannot complete.

Parameters:
CORE_ID, 0, value returned by CSR 0xF14
NUM_CORES, 1, value returned by CSR 0xFC1
FIFO_DEPTH, 4, entries per FIFO; power of two, >=2
CNT_WIDTH, 64, statistics counter width, 32..64

Ports:
Clk  input  1  clock, rising edge
Rst_n  input  1  asynchronous active-low reset
CSR_Read  input  1  CSR read request this cycle
CSR_Write  input  1  CSR write request this cycle
CSR_Address  input  12  CSR address
CSR_Wr_Data  input  32  CSR write data
Completed_Instruction  input  1  one instruction retired this cycle
Stall  output  1  combinational; current access cannot complete, core must hold it
CSR_Rd_Data  output  32  registered read data
CSR_Rd_Valid  output  1  registered; CSR_Rd_Data valid this cycle
Illegal_CSR  output  1  registered one-cycle pulse, illegal access
Mngr2Proc_Data  input  32  manager message
Mngr2Proc_Valid  input  1  manager message valid
Mngr2Proc_Ready  output  1  rx FIFO not full
Proc2Mngr_Data  output  32  tx FIFO head
Proc2Mngr_Valid  output  1  tx FIFO not empty
Proc2Mngr_Ready  input  1  manager accepts head
Clock_Cycles  output  CNT_WIDTH  cycle counter
Completed_Instructions  output  CNT_WIDTH  instret counter

Behaviour:
- Reset (Rst_n low, async): both FIFOs empty, counts 0, stats_en 0, both counters 0, CSR_Rd_Data 0, CSR_Rd_Valid 0, Illegal_CSR 0. Mngr2Proc_Ready and Proc2Mngr_Valid forced 0 while reset is asserted.
- Stall, combinational from registered state:
  - CSR_Read to 0xFC0 with rx empty, OR
  - CSR_Write to 0x7C0 with tx full.
- Access acceptance:
  - An access is accepted when (CSR_Read|CSR_Write) and !Stall.
  - While stalled, neither read nor write side-effect occurs (atomic).
- CSR map (R=read, W=write):
  - 0xF14 R CORE_ID
  - 0xFC1 R NUM_CORES
  - 0x7C1 RW stats_en in bit0, upper bits read 0
  - 0xFC0 R pops rx head
  - 0x7C0 W pushes CSR_Wr_Data to tx
  - 0xC00/0xC80 R Clock_Cycles low/high 32
  - 0xC02/0xC82 R Completed_Instructions low/high 32; high halves zero-extended, 0 when CNT_WIDTH=32
  - 0x7C2 R status: bits[15:8] rx count, [7:0] tx count
- Illegal access: unmapped address, or a write to an R-only address.
  - Illegal_CSR pulses the cycle after acceptance; read data 0, no side-effect.
  - A write to an R-only address that is paired with a legal read of that same address still performs the read.
- Read latency: 1 cycle. CSR_Rd_Valid is high exactly the cycle after an accepted read.
- Simultaneous read and write: the read returns the pre-write value. For 0xFC0 read with 0x7C0 write, both FIFO operations occur.
- rx FIFO:
  - Push on Mngr2Proc_Valid & Mngr2Proc_Ready.
  - Ready = count < FIFO_DEPTH.
  - Pop on accepted 0xFC0 read.
  - Push and pop in the same cycle keep the count unchanged.
  - No bypass: a push into an empty FIFO is readable the next cycle, so a 0xFC0 read stalls the same cycle.
- tx FIFO:
  - Pop on Proc2Mngr_Valid & Proc2Mngr_Ready.
  - Push on accepted 0x7C0 write.
  - A manager pop in the same cycle as a core write while full does not unstall that cycle; the write is accepted next cycle.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
- Counters:
  - When stats_en=1, Clock_Cycles += 1 and Completed_Instructions += Completed_Instruction each cycle, wrapping mod 2^CNT_WIDTH.
  - A write setting stats_en 0→1 clears both counters that edge; counting starts the following cycle.
  - Writing 1 while already 1 does not clear. Writing 0 freezes the values.
- Reset mid-stall or mid-transfer: all FIFO contents discarded; Stall drops with the empty/reset state except for 0xFC0 reads (rx empty after reset).

Test Plan:
1. Reset, then read 0xF14, 0xFC1, 0x7C1 with CORE_ID=2, NUM_CORES=4 → CSR_Rd_Data 2, 4, 0, each one cycle later with CSR_Rd_Valid=1.
2. Manager pushes 0xA, 0xB, 0xC, 0xD (depth 4) → Mngr2Proc_Ready=0 after the 4th. Four 0xFC0 reads return A, B, C, D. A fifth read holds Stall=1 until the manager pushes 0xE, then returns 0xE.
3. Proc2Mngr_Ready=0, core writes 0x7C0 five times (1..5) → 5th write stalls, status reads 0x0004. Raise Ready → manager sees 1..5 in order, Stall clears.
4. Write 0x7C1=1, hold Completed_Instruction=1 for 10 cycles, write 0x7C1=0 → 0xC00 reads 10 or 11 (define exact per edge rule: 10), 0xC02 reads 10. Rewrite 1 → both read 0 next cycle.
5. CNT_WIDTH=64, force Clock_Cycles to 0xFFFFFFFF via 2^32 counting (or backdoor preload) → next cycle 0xC00=0, 0xC80=1.
6. Read 0x123, then write 0xF14 → Illegal_CSR pulses once each, read data 0. Assert Rst_n=0 mid-stall on 0x7C0 → Stall=0, FIFOs empty after release.
